// File: rtl/led_pattern_scheduler.sv
// Status-LED blink scheduler: a 4-deep command FIFO of {rate, repeat} feeding a blink/gap sequencer.
// Optional synchronous abort/flush input is compiled in with the LED_SCHED_ABORT_EN macro.
module led_pattern_scheduler #(
  parameter int unsigned HALF_100   = 125000 - 1,
  parameter int unsigned HALF_50    = 250000 - 1,
  parameter int unsigned HALF_10    = 1250000 - 1,
  parameter int unsigned HALF_1     = 12500000 - 1,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd_rate,
  input  logic [7:0] i_cmd_repeat,
  output logic       o_cmd_ready,
  output logic       o_led_drive,
  output logic [1:0] o_rate_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_fifo_count
`ifdef LED_SCHED_ABORT_EN
  ,
  input  logic       i_abort
`endif
);

  // One shared counter serves both blink phases and the gap, so size it for the largest terminal value.
  localparam int unsigned MAX_A   = (HALF_100 > HALF_50) ? HALF_100 : HALF_50;
  localparam int unsigned MAX_B   = (HALF_10 > HALF_1) ? HALF_10 : HALF_1;
  localparam int unsigned MAX_H   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_ALL = (MAX_H > GAP_CYCLES) ? MAX_H : GAP_CYCLES;
  localparam int unsigned CW      = (MAX_ALL < 2) ? 1 : $clog2(MAX_ALL + 1);

  localparam int unsigned GAP_LAST_I = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  localparam logic [CW-1:0] H100     = CW'(HALF_100);
  localparam logic [CW-1:0] H50      = CW'(HALF_50);
  localparam logic [CW-1:0] H10      = CW'(HALF_10);
  localparam logic [CW-1:0] H1       = CW'(HALF_1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LAST_I);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

  // A command either drops into the dark gap or straight back to IDLE when no gap is configured.
  localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t        state;
  logic [9:0]    fifo_mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;
  logic [7:0]    remaining;
  logic [CW-1:0] cnt;
  logic          phase_on;
  logic          push;
  logic          pop;
  logic          abort;
  logic [CW-1:0] half_sel;
  logic [1:0]    head_rate;
  logic [7:0]    head_repeat;

`ifdef LED_SCHED_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  assign o_cmd_ready  = (count != 3'd4);
  assign o_fifo_count = count;
  assign o_busy       = (state != IDLE);

  assign push        = i_cmd_valid && o_cmd_ready && !abort;
  assign pop         = (state == LOAD) && !abort;
  assign head_rate   = fifo_mem[rd_ptr][9:8];
  assign head_repeat = fifo_mem[rd_ptr][7:0];

  always_comb begin
    half_sel = H100;
    case (o_rate_sel)
      2'b00:   half_sel = H100;
      2'b01:   half_sel = H50;
      2'b10:   half_sel = H10;
      default: half_sel = H1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {i_cmd_rate, i_cmd_repeat};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else if (abort) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      o_rate_sel  <= 2'b00;
      remaining   <= 8'd0;
      cnt         <= '0;
      phase_on    <= 1'b0;
      o_led_drive <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        remaining   <= 8'd0;
        cnt         <= '0;
        phase_on    <= 1'b0;
        o_led_drive <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            // A zero-repeat command completes in LOAD, so its done pulse is raised on entry to LOAD.
            if (count != 3'd0) begin
              state  <= LOAD;
              o_done <= (head_repeat == 8'd0);
            end
          end
          LOAD: begin
            o_rate_sel <= head_rate;
            remaining  <= head_repeat;
            cnt        <= '0;
            if (head_repeat == 8'd0) begin
              state <= POST;
            end else begin
              state       <= RUN;
              phase_on    <= 1'b1;
              o_led_drive <= 1'b1;
            end
          end
          RUN: begin
            if (cnt == half_sel) begin
              cnt <= '0;
              if (phase_on) begin
                phase_on    <= 1'b0;
                o_led_drive <= 1'b0;
              end else if (remaining == 8'd1) begin
                remaining <= 8'd0;
                o_done    <= 1'b1;
                state     <= POST;
              end else begin
                remaining   <= remaining - 8'd1;
                phase_on    <= 1'b1;
                o_led_drive <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Self-checking bench for led_pattern_scheduler: a per-cycle timeline model plus directed literal checks.
module tb_led_pattern_scheduler;
  localparam int H100 = 3;
  localparam int H50  = 5;
  localparam int H10  = 7;
  localparam int H1   = 9;
  localparam int GAPC = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_rate;
  logic [7:0] cmd_repeat;
  logic       abort;
  logic       cmd_ready;
  logic       led;
  logic [1:0] rate_sel;
  logic       busy;
  logic       done;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;

  led_pattern_scheduler #(
    .HALF_100(H100), .HALF_50(H50), .HALF_10(H10), .HALF_1(H1), .GAP_CYCLES(GAPC)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_cmd_valid(cmd_valid),
    .i_cmd_rate(cmd_rate),
    .i_cmd_repeat(cmd_repeat),
    .o_cmd_ready(cmd_ready),
    .o_led_drive(led),
    .o_rate_sel(rate_sel),
    .o_busy(busy),
    .o_done(done),
    .o_fifo_count(fifo_count)
`ifdef LED_SCHED_ABORT_EN
    ,
    .i_abort(abort)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each accepted command expands into a list of per-cycle output records.
  typedef struct packed {
    logic       led;
    logic [1:0] rate;
    logic       busy;
    logic       done;
    logic       pop;
  } rec_t;

  logic [9:0] q[$];
  rec_t       plan[$];
  rec_t       cur;
  bit         m_push;
  bit         m_abort;

  function automatic int half_of(input logic [1:0] r);
    case (r)
      2'd0:    return H100;
      2'd1:    return H50;
      2'd2:    return H10;
      default: return H1;
    endcase
  endfunction

  task automatic build(input logic [9:0] e);
    int   h;
    int   n;
    rec_t r;
    h = half_of(e[9:8]);
    n = int'(e[7:0]);
    r = '0; r.rate = cur.rate; r.busy = 1'b1; r.done = (n == 0);
    plan.push_back(r);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 2 * (h + 1); c++) begin
        r = '0; r.led = (c <= h); r.rate = e[9:8]; r.busy = 1'b1; r.pop = (i == 0 && c == 0);
        plan.push_back(r);
      end
    end
    for (int g = 0; g < GAPC; g++) begin
      r = '0; r.rate = e[9:8]; r.busy = 1'b1; r.done = (g == 0 && n > 0); r.pop = (g == 0 && n == 0);
      plan.push_back(r);
    end
    r = '0; r.rate = e[9:8]; r.done = (GAPC == 0 && n > 0); r.pop = (GAPC == 0 && n == 0);
    plan.push_back(r);
  endtask

  initial begin
    cur = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        plan.delete();
        cur = '0;
      end else begin
        m_abort = abort;
        m_push  = cmd_valid && (q.size() < 4) && !m_abort;
        if (m_abort) begin
          q.delete();
          plan.delete();
          cur.led = 1'b0; cur.busy = 1'b0; cur.done = 1'b0; cur.pop = 1'b0;
        end else begin
          if (plan.size() == 0 && q.size() > 0) build(q[0]);
          if (plan.size() > 0) begin
            cur = plan.pop_front();
          end else begin
            cur.led = 1'b0; cur.busy = 1'b0; cur.done = 1'b0; cur.pop = 1'b0;
          end
          if (cur.pop) void'(q.pop_front());
        end
        if (m_push) q.push_back({cmd_rate, cmd_repeat});
      end
    end
  end

  initial begin
    logic [8:0] act;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (check_en) begin
        act = {led, rate_sel, busy, done, fifo_count, cmd_ready};
        exp = {cur.led, cur.rate, cur.busy, cur.done, 3'(q.size()), (q.size() < 4)};
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL cycle_model t=%0t {led,rate,busy,done,count,ready} got=%b want=%b", $time, act, exp);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic [1:0] r, input logic [7:0] n, output int waited);
    bit acc;
    acc = 0;
    waited = 0;
    cmd_valid = 1'b1; cmd_rate = r; cmd_repeat = n;
    for (int k = 0; k < 400; k++) begin
      if (cmd_ready) begin
        acc = 1;
        @(negedge clk);
        break;
      end
      waited++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    $display("push rate=%0d repeat=%0d waited=%0d accepted=%0d", r, n, waited, acc);
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!busy && fifo_count == 3'd0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int w;
    int on_cnt;
    int dn_cnt;
    int gap_cnt;
    int iters;
    bit seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rate = 2'd0; cmd_repeat = 8'd0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1;
    check("reset_led", int'(led), 0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_count", int'(fifo_count), 0);
    check("reset_busy_done_rate", int'({busy, done, rate_sel}), 0);

    // {00, 2}: LED up after edge 2, 4 on / 4 off twice, one done, 4 gap cycles.
    push_cmd(2'd0, 8'd2, w);
    check("s1_idle_after_accept", int'({busy, fifo_count}), 1);
    @(negedge clk);
    check("s1_load_busy_led", int'({busy, led}), 2);
    @(negedge clk);
    check("s1_led_latency", int'(led), 1);
    on_cnt = 0; dn_cnt = 0; gap_cnt = 0; iters = 0; seen = 0;
    for (int k = 0; k < 200 && busy; k++) begin
      on_cnt += int'(led);
      if (done) seen = 1;
      dn_cnt += int'(done);
      if (seen) gap_cnt++;
      iters++;
      @(negedge clk);
    end
    $display("s1 on=%0d done=%0d gap=%0d busy_after_load=%0d", on_cnt, dn_cnt, gap_cnt, iters);
    check("s1_on_cycles", on_cnt, 8);
    check("s1_done_pulses", dn_cnt, 1);
    check("s1_gap_cycles", gap_cnt, 4);
    check("s1_busy_cycles", iters, 20);

    // {11, 0}: done during LOAD, no LED, then a 4-cycle gap.
    push_cmd(2'd3, 8'd0, w);
    @(negedge clk);
    check("s3_done_in_load", int'({busy, done, led}), 6);
    @(negedge clk);
    on_cnt = 0; iters = 0;
    for (int k = 0; k < 50 && busy; k++) begin
      on_cnt += int'(led) + int'(done);
      iters++;
      @(negedge clk);
    end
    check("s3_gap_len", iters, 4);
    check("s3_no_led_no_extra_done", on_cnt, 0);
    check("s3_rate_latched", int'(rate_sel), 3);

    // Fill the FIFO behind a running command; the fifth push must stall until the next pop.
    push_cmd(2'd1, 8'd3, w);
    @(negedge clk);
    @(negedge clk);
    push_cmd(2'd0, 8'd1, w);
    push_cmd(2'd2, 8'd1, w);
    push_cmd(2'd3, 8'd1, w);
    push_cmd(2'd0, 8'd0, w);
    check("s2_full_count", int'(fifo_count), 4);
    check("s2_full_ready", int'(cmd_ready), 0);
    push_cmd(2'd1, 8'd2, w);
    check("s2_fifth_held", int'(w > 0), 1);
    wait_idle();

    // Reset in the middle of an ON phase with commands still queued.
    push_cmd(2'd3, 8'd2, w);
    push_cmd(2'd0, 8'd1, w);
    for (int k = 0; k < 20 && !led; k++) @(negedge clk);
    check("s5_led_on_before_reset", int'(led), 1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_led_off", int'(led), 0);
    check("s5_async_count", int'(fifo_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s5_post_reset_state", int'({busy, fifo_count, cmd_ready}), 1);

`ifdef LED_SCHED_ABORT_EN
    push_cmd(2'd0, 8'd2, w);
    push_cmd(2'd1, 8'd1, w);
    push_cmd(2'd2, 8'd1, w);
    for (int k = 0; k < 20 && !led; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_led_count_busy", int'({led, fifo_count, busy}), 0);
    dn_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      dn_cnt += int'(done);
      @(negedge clk);
    end
    check("ab_no_done", dn_cnt, 0);
`endif

    // Random traffic checked cycle by cycle against the model.
    for (int k = 0; k < 2500; k++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_rate   = 2'($urandom_range(0, 3));
      cmd_repeat = 8'($urandom_range(0, 2));
`ifdef LED_SCHED_ABORT_EN
      abort = ($urandom_range(0, 199) == 0);
`endif
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    wait_idle();
    check("final_count", int'(fifo_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
